// File: rtl/filter_stream_resp_if.sv
// Response stream bundle between the filter streamer and a PE.
//
// Handshake: a beat moves on a rising clock edge where resp_valid and
// resp_ready are both 1. While resp_valid=1 and resp_ready=0 the master
// holds resp_valid, resp_data and resp_last unchanged. resp_valid never
// depends on resp_ready.
//
// Signals:
//   resp_valid - beat valid (master -> slave)
//   resp_data  - F*DATA_W bit beat payload (master -> slave)
//   resp_last  - final beat of the filter group (master -> slave)
//   resp_ready - slave can accept a beat (slave -> master)
interface filter_stream_resp_if #(
    parameter int F      = 4,
    parameter int DATA_W = 16
);
    logic                  resp_valid;
    logic [F*DATA_W-1:0]   resp_data;
    logic                  resp_last;
    logic                  resp_ready;

    modport master (
        output resp_valid,
        output resp_data,
        output resp_last,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_data,
        input  resp_last,
        output resp_ready
    );
endinterface

// File: rtl/filter_stream_resp.sv
// Filter stream responder: on a PE request, reads one filter group from the
// filter SRAM and streams it back as response beats through a 2-entry FIFO.
//
// Ports:
//   clk                  - clock, rising edge
//   rst                  - synchronous active-low reset
//   req_filter_valid     - level request, held by the PE until finish
//   req_filter_k         - requested filter group
//   cfg_base_addr        - layer filter base address
//   cfg_beats_per_k      - beats per filter group
//   mem_rd_en/addr       - SRAM read strobe and address
//   mem_rd_data          - SRAM data, valid one cycle after mem_rd_en
//   resp                 - response stream (master side of the interface)
//   stream_filter_finish - one-cycle pulse when the group is complete
//   dbg_state            - current FSM state (0 IDLE,1 FETCH,2 DRAIN,3 DONE)
module filter_stream_resp #(
    parameter int F      = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int K_W    = 4,
    parameter int LEN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_filter_valid,
    input  logic [K_W-1:0]        req_filter_k,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [LEN_W-1:0]      cfg_beats_per_k,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [F*DATA_W-1:0]   mem_rd_data,
    filter_stream_resp_if.master  resp,
    output logic                  stream_filter_finish,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int PROD_W = K_W + LEN_W;
    localparam int CALC_W = (PROD_W > ADDR_W) ? PROD_W : ADDR_W;

    state_t                state;
    logic [LEN_W-1:0]      beats_q;
    logic [LEN_W-1:0]      beats_m1;
    logic [LEN_W-1:0]      issue_cnt;
    logic [LEN_W-1:0]      beat_cnt;
    logic [ADDR_W-1:0]     addr_q;
    logic                  inflight;
    logic                  finish_q;

    logic [F*DATA_W-1:0]   fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;

    logic [CALC_W-1:0]     start_sum;
    logic [ADDR_W-1:0]     start_addr;
    logic                  resp_valid_int;
    logic                  pop;
    logic                  push;
    logic [2:0]            eff_occ;
    logic                  rd_go;

    // Group start address; the sum is formed wide and then truncated.
    assign start_sum  = CALC_W'(cfg_base_addr)
                      + CALC_W'(req_filter_k) * CALC_W'(cfg_beats_per_k);
    assign start_addr = start_sum[ADDR_W-1:0];

    assign beats_m1       = beats_q - 1'b1;
    assign resp_valid_int = (fifo_cnt != 2'd0);
    assign pop            = resp_valid_int & resp.resp_ready;
    assign push           = inflight;

    // Occupancy excludes the entry leaving this cycle, so a read can be
    // issued every cycle while the PE keeps resp_ready high.
    assign eff_occ = {1'b0, fifo_cnt} - {2'b00, pop} + {2'b00, inflight};
    assign rd_go   = (state == S_FETCH) && (beats_q != '0) && (eff_occ < 3'd2);

    assign mem_rd_en   = rd_go;
    assign mem_rd_addr = rd_go ? addr_q : '0;

    assign resp.resp_valid = resp_valid_int;
    assign resp.resp_data  = resp_valid_int ? fifo_mem[rd_ptr] : '0;
    assign resp.resp_last  = resp_valid_int && (beat_cnt == beats_m1);

    assign stream_filter_finish = finish_q;
    assign dbg_state            = state;

    // FIFO storage carries no reset; emptiness is tracked by fifo_cnt.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            beats_q   <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            addr_q    <= '0;
            inflight  <= 1'b0;
            finish_q  <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            finish_q <= 1'b0;
            // A read issued this cycle returns data on the next edge.
            inflight <= rd_go;

            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                beat_cnt <= beat_cnt + 1'b1;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

            if (rd_go) begin
                addr_q    <= addr_q + 1'b1;
                issue_cnt <= issue_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (req_filter_valid) begin
                        addr_q    <= start_addr;
                        beats_q   <= cfg_beats_per_k;
                        issue_cnt <= '0;
                        beat_cnt  <= '0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (beats_q == '0) begin
                        state    <= S_DONE;
                        finish_q <= 1'b1;
                    end else if (rd_go && (issue_cnt == beats_m1)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && resp.resp_last) begin
                        state    <= S_DONE;
                        finish_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Held request must drop before another is accepted.
                    if (!req_filter_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_filter_stream_resp.sv
// Testbench for filter_stream_resp: SRAM model, request driver tasks,
// scoreboard of expected beats/addresses, and a negedge monitor.
module tb_filter_stream_resp;
    localparam int F      = 4;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int K_W    = 4;
    localparam int LEN_W  = 8;
    localparam int DW     = F * DATA_W;
    localparam int W      = DW + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                req_filter_valid = 1'b0;
    logic [K_W-1:0]      req_filter_k = '0;
    logic [ADDR_W-1:0]   cfg_base_addr = '0;
    logic [LEN_W-1:0]    cfg_beats_per_k = '0;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_rd_addr;
    logic [DW-1:0]       mem_rd_data = '0;
    logic                stream_filter_finish;
    logic [1:0]          dbg_state;
    logic                ready = 1'b1;

    filter_stream_resp_if #(.F(F), .DATA_W(DATA_W)) resp_if ();
    assign resp_if.resp_ready = ready;

    filter_stream_resp #(
        .F(F), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .K_W(K_W), .LEN_W(LEN_W)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_filter_valid     (req_filter_valid),
        .req_filter_k         (req_filter_k),
        .cfg_base_addr        (cfg_base_addr),
        .cfg_beats_per_k      (cfg_beats_per_k),
        .mem_rd_en            (mem_rd_en),
        .mem_rd_addr          (mem_rd_addr),
        .mem_rd_data          (mem_rd_data),
        .resp                 (resp_if),
        .stream_filter_finish (stream_filter_finish),
        .dbg_state            (dbg_state)
    );

    // SRAM model: one-cycle read latency
    logic [DW-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= sram[mem_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ready pattern: 0 = always 1, 1 = 1,0,0 repeating, 2 = random 50%
    int ready_mode = 0;
    int ready_ph = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: ready = 1'b1;
            1: begin
                ready = (ready_ph == 0);
                ready_ph = (ready_ph == 2) ? 0 : ready_ph + 1;
            end
            default: ready = 1'($urandom_range(0, 1));
        endcase
    end

    // scoreboard
    logic [W-1:0]      exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=present required=absent (cycle %0d)", name, cyc);
    endtask

    // monitor state
    int beat_seen, last_seen, fin_seen;
    int first_cyc, last_cyc, fin_cyc;
    int reads_issued = 0;
    int beats_taken = 0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            prev_stall   = 1'b0;
            reads_issued = 0;
            beats_taken  = 0;
        end else begin
            if (mem_rd_en) begin
                reads_issued++;
                if (addr_q.size() == 0) fail("unexpected_read");
                else check("rd_addr", 128'(mem_rd_addr), 128'(addr_q.pop_front()));
            end
            if (prev_stall) begin
                check("stall_valid", 128'(resp_if.resp_valid), 128'(1));
                check("stall_data", 128'(resp_if.resp_data), 128'(prev_data));
            end
            if (resp_if.resp_valid && first_cyc < 0) first_cyc = cyc;
            if (resp_if.resp_valid && resp_if.resp_ready) begin
                beats_taken++;
                beat_seen++;
                if (resp_if.resp_last) begin
                    last_seen++;
                    last_cyc = cyc;
                end
                if (exp_q.size() == 0) fail("unexpected_beat");
                else begin
                    e = exp_q.pop_front();
                    check("resp_data", 128'(resp_if.resp_data), 128'(e[DW-1:0]));
                    check("resp_last", 128'(resp_if.resp_last), 128'(e[DW]));
                end
            end
            check("outstanding_le2", 128'(reads_issued - beats_taken <= 2), 128'(1));
            if (stream_filter_finish) begin
                fin_seen++;
                fin_cyc = cyc;
            end
            prev_stall = resp_if.resp_valid && !resp_if.resp_ready;
            prev_data  = resp_if.resp_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_seen();
        beat_seen = 0; last_seen = 0; fin_seen = 0;
        first_cyc = -1; last_cyc = -1; fin_cyc = -1;
    endtask

    task automatic push_expect(input int k, input int base, input int beats);
        int a;
        for (int i = 0; i < beats; i++) begin
            a = (base + k * beats + i) % DEPTH;
            addr_q.push_back(ADDR_W'(a));
            exp_q.push_back({(i == beats - 1), sram[a]});
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"}, 128'(mem_rd_en), 128'(0));
        check({tag, "_rd_addr"}, 128'(mem_rd_addr), 128'(0));
        check({tag, "_valid"}, 128'(resp_if.resp_valid), 128'(0));
        check({tag, "_data"}, 128'(resp_if.resp_data), 128'(0));
        check({tag, "_last"}, 128'(resp_if.resp_last), 128'(0));
        check({tag, "_finish"}, 128'(stream_filter_finish), 128'(0));
        check({tag, "_state"}, 128'(dbg_state), 128'(0));
    endtask

    // One complete request. Call at a posedge+#1 point with the DUT idle.
    task automatic run_req(input int k, input int base, input int beats,
                           input int mode, input bit timing, input int hold);
        int n;
        int budget;
        ready_mode = mode;
        push_expect(k, base, beats);
        req_filter_k     = K_W'(k);
        cfg_base_addr    = ADDR_W'(base);
        cfg_beats_per_k  = LEN_W'(beats);
        clear_seen();
        req_filter_valid = 1'b1;
        n = cyc;
        budget = 0;
        while (fin_seen == 0 && budget < 3000) begin
            tick();
            // inputs are latched once; later changes must be ignored
            req_filter_k    = K_W'($urandom);
            cfg_base_addr   = ADDR_W'($urandom);
            cfg_beats_per_k = LEN_W'($urandom);
            budget++;
        end
        check("finish_seen", 128'(fin_seen != 0), 128'(1));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("held_in_done", 128'(dbg_state), 128'(3));
        end
        req_filter_valid = 1'b0;
        tick();
        check("back_to_idle", 128'(dbg_state), 128'(0));
        repeat (3) tick();
        check("beat_count", 128'(beat_seen), 128'(beats));
        check("last_count", 128'(last_seen), 128'(beats > 0 ? 1 : 0));
        check("finish_count", 128'(fin_seen), 128'(1));
        check("exp_q_empty", 128'(exp_q.size()), 128'(0));
        check("addr_q_empty", 128'(addr_q.size()), 128'(0));
        if (timing) begin
            if (beats > 0) begin
                check("first_beat_latency", 128'(first_cyc - n), 128'(3));
                check("beats_back_to_back", 128'(last_cyc - first_cyc), 128'(beats - 1));
                check("finish_after_last", 128'(fin_cyc - last_cyc), 128'(1));
            end else begin
                check("zero_beat_finish", 128'(fin_cyc - n), 128'(2));
            end
        end
    endtask

    // Reset pulse while the second of four beats is presented.
    task automatic reset_mid();
        int budget;
        ready_mode = 0;
        push_expect(1, 'h200, 4);
        req_filter_k     = K_W'(1);
        cfg_base_addr    = ADDR_W'('h200);
        cfg_beats_per_k  = LEN_W'(4);
        clear_seen();
        req_filter_valid = 1'b1;
        budget = 0;
        while (beat_seen == 0 && budget < 50) begin
            tick();
            budget++;
        end
        check("mid_first_beat", 128'(beat_seen), 128'(1));
        check("mid_second_valid", 128'(resp_if.resp_valid), 128'(1));
        rst = 1'b0;
        req_filter_valid = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        check_outputs_zero("mid_rst");
        repeat (6) tick();
        check("mid_no_finish", 128'(fin_seen), 128'(0));
        check("mid_no_more_beats", 128'(beat_seen), 128'(1));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] = {$urandom, $urandom};
        clear_seen();

        // reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check_outputs_zero("reset");
        tick();
        check_outputs_zero("idle");

        // base 0x100, k 2, three beats, ready high
        run_req(2, 'h100, 3, 0, 1'b1, 0);

        // four beats with ready 1,0,0 pattern
        run_req(3, 'h040, 4, 1, 1'b0, 0);

        // zero beats
        run_req(5, 'h300, 0, 0, 1'b1, 0);

        // request held after finish
        run_req(1, 'h010, 2, 0, 1'b0, 5);
        run_req(0, 'h020, 3, 2, 1'b0, 0);

        // reset mid-stream, then a fresh request
        reset_mid();
        run_req(1, 'h200, 4, 0, 1'b1, 0);

        // address wrap at the top of the SRAM
        run_req(0, 'hffe, 4, 0, 1'b0, 0);

        // largest group with random backpressure
        run_req(int'($urandom_range(0, 15)), int'($urandom_range(0, DEPTH - 1)), 255, 2, 1'b0, 0);

        // random groups
        for (int r = 0; r < 8; r++) begin
            run_req(int'($urandom_range(0, 15)), int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(1, 12)), int'($urandom_range(0, 2)), 1'b0,
                    int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
